// File: rtl/x_bus_caster.sv
// rtl/x_bus_caster.sv - X-direction caster between the global bus and one row of PEs
// One transaction in flight: pulse the addressed PE, wait PE_LAT cycles, return its opsum.
module x_bus_caster #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int PE_LAT     = 2,
  localparam int PW        = 2 * DATA_WIDTH,
  localparam int CW        = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int CNT_W     = (PE_LAT > 1) ? $clog2(PE_LAT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bus_valid_i,
  output logic                  bus_ready_o,
  input  logic [DATA_WIDTH-1:0] bus_ifmap_i,
  input  logic [DATA_WIDTH-1:0] bus_fltr_i,
  input  logic [PW-1:0]         bus_ipsum_i,
  input  logic [CW-1:0]         bus_col_i,
  output logic [PW-1:0]         bus_opsum_o,
  output logic                  bus_opsum_valid_o,
  output logic                  cast_err_o,
  output logic [DATA_WIDTH-1:0] pe_ifmap_o,
  output logic [DATA_WIDTH-1:0] pe_fltr_o,
  output logic [PW-1:0]         pe_ipsum_o,
  output logic [NUM_COL-1:0]    pe_en_o,
  input  logic [NUM_COL*PW-1:0] pe_opsum_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_en_q;
  logic                  cast_err_q;
  logic [DATA_WIDTH-1:0] ifmap_q, fltr_q;
  logic [PW-1:0]         ipsum_q, opsum_q, opsum_sel;
  logic [CW-1:0]         col_q;
  logic                  accept, col_ok;

  // ready_en_q keeps bus_ready low while reset is asserted and until the first edge after it.
  assign bus_ready_o       = ready_en_q && (state_q == S_IDLE);
  assign accept            = bus_valid_i && bus_ready_o;
  assign col_ok            = int'(bus_col_i) < NUM_COL;
  assign bus_opsum_o       = opsum_q;
  assign bus_opsum_valid_o = (state_q == S_RESP);
  assign cast_err_o        = cast_err_q;
  assign pe_ifmap_o        = ifmap_q;
  assign pe_fltr_o         = fltr_q;
  assign pe_ipsum_o        = ipsum_q;

  always_comb begin
    opsum_sel = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      if (int'(col_q) == k) opsum_sel = pe_opsum_i[k*PW +: PW];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pe_en_o = '0;
    case (state_q)
      S_IDLE: begin
        if (accept && col_ok) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        for (int k = 0; k < NUM_COL; k++) pe_en_o[k] = (int'(col_q) == k);
        cnt_d   = CNT_W'(PE_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
      cast_err_q <= 1'b0;
      ifmap_q    <= '0;
      fltr_q     <= '0;
      ipsum_q    <= '0;
      col_q      <= '0;
      opsum_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
      cast_err_q <= accept && !col_ok;
      if (accept) begin
        ifmap_q <= bus_ifmap_i;
        fltr_q  <= bus_fltr_i;
        ipsum_q <= bus_ipsum_i;
        col_q   <= bus_col_i;
      end
      if (state_q == S_WAIT && cnt_q == '0) opsum_q <= opsum_sel;
    end
  end

endmodule

// File: tb/tb_x_bus_caster.sv
// tb/tb_x_bus_caster.sv - directed bench for x_bus_caster
// Three builds: (4 col, lat 2), (3 col, lat 5), (4 col, lat 1), each with a timed PE row model.
module tb_x_bus_caster;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic        rst             [NI];
  logic        bus_valid       [NI];
  logic        bus_ready       [NI];
  logic [15:0] bus_ifmap       [NI];
  logic [15:0] bus_fltr        [NI];
  logic [31:0] bus_ipsum       [NI];
  logic [1:0]  bus_col         [NI];
  logic [31:0] bus_opsum       [NI];
  logic        bus_opsum_valid [NI];
  logic        cast_err        [NI];
  logic [15:0] pe_ifmap        [NI];
  logic [15:0] pe_fltr         [NI];
  logic [31:0] pe_ipsum        [NI];
  logic [3:0]  pe_en           [NI];

  function automatic int nc_of(input int g);
    return (g == 1) ? 3 : 4;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 5 : 1);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int NC  = (g == 1) ? 3 : 4;
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 5 : 1);
    logic [NC-1:0]    en_v;
    logic [NC*32-1:0] opsum_v;
    logic [31:0]      res [NC];
    int               cnt [NC];

    x_bus_caster #(.DATA_WIDTH(16), .NUM_COL(NC), .PE_LAT(LAT)) u_dut (
      .clk_i            (clk),
      .rst_i            (rst[g]),
      .bus_valid_i      (bus_valid[g]),
      .bus_ready_o      (bus_ready[g]),
      .bus_ifmap_i      (bus_ifmap[g]),
      .bus_fltr_i       (bus_fltr[g]),
      .bus_ipsum_i      (bus_ipsum[g]),
      .bus_col_i        (bus_col[g]),
      .bus_opsum_o      (bus_opsum[g]),
      .bus_opsum_valid_o(bus_opsum_valid[g]),
      .cast_err_o       (cast_err[g]),
      .pe_ifmap_o       (pe_ifmap[g]),
      .pe_fltr_o        (pe_fltr[g]),
      .pe_ipsum_o       (pe_ipsum[g]),
      .pe_en_o          (en_v),
      .pe_opsum_i       (opsum_v)
    );

    assign pe_en[g] = 4'(en_v);

    // PE result is only presented in the single cycle it is due; otherwise a marker value.
    initial for (int k = 0; k < NC; k++) cnt[k] = 0;
    always @(posedge clk) begin
      for (int k = 0; k < NC; k++) begin
        if (en_v[k]) begin
          res[k] <= 32'(pe_ifmap[g]) * 32'(pe_fltr[g]) + pe_ipsum[g];
          cnt[k] <= LAT;
        end else if (cnt[k] > 0) begin
          cnt[k] <= cnt[k] - 1;
        end
      end
    end

    always_comb begin
      opsum_v = '0;
      for (int k = 0; k < NC; k++)
        opsum_v[k*32 +: 32] = (cnt[k] == 1) ? res[k] : (32'hDEAD_0000 + 32'(k));
    end
  end

  // Called at a negedge; returns at the negedge of the last checked cycle.
  task automatic cast(input string name, input int g, input logic [1:0] col,
                      input logic [15:0] ifm, input logic [15:0] flt, input logic [31:0] ips,
                      input logic [31:0] exp_op, input bit keep,
                      input logic [1:0] ncol, input logic [15:0] nifm,
                      input logic [15:0] nflt, input logic [31:0] nips, output int acc);
    int lat;
    int w;
    bit err;
    logic [3:0] e_en;
    lat = lat_of(g);
    err = (int'(col) >= nc_of(g));
    bus_col[g]   = col;
    bus_ifmap[g] = ifm;
    bus_fltr[g]  = flt;
    bus_ipsum[g] = ips;
    bus_valid[g] = 1'b1;
    w = 0;
    while (bus_ready[g] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    acc = cyc;
    n_checks++;
    if (bus_ready[g] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_timeout: bus_ready=%b required 1", name, bus_ready[g]);
      bus_valid[g] = 1'b0;
      return;
    end
    @(negedge clk);
    if (keep) begin
      bus_col[g]   = ncol;
      bus_ifmap[g] = nifm;
      bus_fltr[g]  = nflt;
      bus_ipsum[g] = nips;
    end else begin
      bus_valid[g] = 1'b0;
    end
    for (int n = 1; n <= lat + 2; n++) begin
      e_en = (n == 1 && !err) ? (4'b0001 << col) : 4'b0000;
      n_checks++;
      if (pe_en[g] !== e_en) begin
        n_errors++;
        $display("FAIL %s pe_en n=%0d: got %b required %b", name, n, pe_en[g], e_en);
      end
      n_checks++;
      if (bus_opsum_valid[g] !== (!err && n == lat + 2)) begin
        n_errors++;
        $display("FAIL %s opsum_valid n=%0d: got %b required %b", name, n,
                 bus_opsum_valid[g], (!err && n == lat + 2));
      end
      n_checks++;
      if (cast_err[g] !== (err && n == 1)) begin
        n_errors++;
        $display("FAIL %s cast_err n=%0d: got %b required %b", name, n, cast_err[g], (err && n == 1));
      end
      n_checks++;
      if (bus_ready[g] !== err) begin
        n_errors++;
        $display("FAIL %s bus_ready n=%0d: got %b required %b", name, n, bus_ready[g], err);
      end
      if (n == 1 && !err) begin
        n_checks++;
        if (pe_ifmap[g] !== ifm || pe_fltr[g] !== flt || pe_ipsum[g] !== ips) begin
          n_errors++;
          $display("FAIL %s pe_payload: got %h/%h/%h required %h/%h/%h", name,
                   pe_ifmap[g], pe_fltr[g], pe_ipsum[g], ifm, flt, ips);
        end
      end
      if (n == lat + 2 && !err) begin
        n_checks++;
        if (bus_opsum[g] !== exp_op) begin
          n_errors++;
          $display("FAIL %s bus_opsum: got %h required %h", name, bus_opsum[g], exp_op);
        end
      end
      if (n < lat + 2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < NI; g++) begin
      rst[g] = 1'b1; bus_valid[g] = 1'b0; bus_col[g] = '0;
      bus_ifmap[g] = '0; bus_fltr[g] = '0; bus_ipsum[g] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_ready[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL reset ready_in_reset: got %b required 0", bus_ready[0]);
    end
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      n_checks++;
      if (bus_ready[g] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset ready_after[%0d]: got %b required 1", g, bus_ready[g]);
      end
    end
    n_checks++;
    if (pe_en[0] !== 4'b0 || bus_opsum_valid[0] !== 1'b0 || cast_err[0] !== 1'b0 ||
        bus_opsum[0] !== 32'h0 || pe_ifmap[0] !== 16'h0 || pe_fltr[0] !== 16'h0 ||
        pe_ipsum[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL reset outputs: got en=%b v=%b err=%b op=%h if=%h fl=%h ip=%h required all 0",
               pe_en[0], bus_opsum_valid[0], cast_err[0], bus_opsum[0], pe_ifmap[0],
               pe_fltr[0], pe_ipsum[0]);
    end
  endtask

  task automatic test_single();
    int a;
    cast("single", 0, 2'd2, 16'h0003, 16'h0004, 32'h0000_0010, 32'h0000_001C,
         1'b0, 2'd0, 16'h0, 16'h0, 32'h0, a);
    @(negedge clk);
    n_checks++;
    if (bus_opsum_valid[0] !== 1'b0 || bus_opsum[0] !== 32'h0000_001C) begin
      n_errors++;
      $display("FAIL single hold: got v=%b op=%h required v=0 op=0000001c",
               bus_opsum_valid[0], bus_opsum[0]);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, a3;
    cast("b2b_c0", 0, 2'd0, 16'h0005, 16'h0006, 32'h0000_0001, 32'h0000_001F,
         1'b1, 2'd1, 16'h0010, 16'h0010, 32'h0, a0);
    cast("b2b_c1", 0, 2'd1, 16'h0010, 16'h0010, 32'h0, 32'h0000_0100,
         1'b1, 2'd2, 16'hFFFF, 16'hFFFF, 32'h0, a1);
    cast("b2b_c2", 0, 2'd2, 16'hFFFF, 16'hFFFF, 32'h0, 32'hFFFE_0001,
         1'b1, 2'd3, 16'h0002, 16'h0003, 32'hFFFF_FFF0, a2);
    cast("b2b_c3", 0, 2'd3, 16'h0002, 16'h0003, 32'hFFFF_FFF0, 32'hFFFF_FFF6,
         1'b0, 2'd0, 16'h0, 16'h0, 32'h0, a3);
    n_checks++;
    if (a1 - a0 != 5 || a2 - a1 != 5 || a3 - a2 != 5) begin
      n_errors++;
      $display("FAIL b2b spacing: got %0d/%0d/%0d required 5/5/5", a1 - a0, a2 - a1, a3 - a2);
    end
  endtask

  task automatic test_out_of_range();
    int a;
    cast("oor_col3", 1, 2'd3, 16'h0007, 16'h0008, 32'h0000_0001, 32'h0,
         1'b0, 2'd0, 16'h0, 16'h0, 32'h0, a);
    @(negedge clk);
    cast("oor_next", 1, 2'd2, 16'h0007, 16'h0008, 32'h0000_0001, 32'h0000_0039,
         1'b0, 2'd0, 16'h0, 16'h0, 32'h0, a);
    @(negedge clk);
    cast("oor_col0", 1, 2'd0, 16'h0100, 16'h0100, 32'h0000_0002, 32'h0001_0002,
         1'b0, 2'd0, 16'h0, 16'h0, 32'h0, a);
  endtask

  task automatic test_reset_abort(input int offset);
    int w;
    bus_col[0] = 2'd1; bus_ifmap[0] = 16'h0009; bus_fltr[0] = 16'h0009; bus_ipsum[0] = 32'h0;
    bus_valid[0] = 1'b1;
    w = 0;
    while (bus_ready[0] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    bus_valid[0] = 1'b0;
    for (int i = 1; i < offset; i++) @(negedge clk);
    n_checks++;
    if (pe_en[0] !== ((offset == 1) ? 4'b0010 : 4'b0000)) begin
      n_errors++;
      $display("FAIL abort%0d pre_en: got %b required %b", offset, pe_en[0],
               ((offset == 1) ? 4'b0010 : 4'b0000));
    end
    rst[0] = 1'b1;
    #1;
    n_checks++;
    if (pe_en[0] !== 4'b0 || bus_opsum_valid[0] !== 1'b0 || bus_ready[0] !== 1'b0 ||
        bus_opsum[0] !== 32'h0) begin
      n_errors++;
      $display("FAIL abort%0d async: got en=%b v=%b rdy=%b op=%h required 0/0/0/0", offset,
               pe_en[0], bus_opsum_valid[0], bus_ready[0], bus_opsum[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (pe_en[0] !== 4'b0 || bus_opsum_valid[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL abort%0d quiet[%0d]: got en=%b v=%b required 0/0", offset, i,
                 pe_en[0], bus_opsum_valid[0]);
      end
    end
    cast("abort_fresh", 0, 2'd1, 16'h0009, 16'h0009, 32'h0, 32'h0000_0051,
         1'b0, 2'd0, 16'h0, 16'h0, 32'h0, w);
    @(negedge clk);
  endtask

  task automatic test_lat1();
    int a;
    cast("lat1", 2, 2'd1, 16'h00FF, 16'h0100, 32'h0000_0005, 32'h0000_FF05,
         1'b0, 2'd0, 16'h0, 16'h0, 32'h0, a);
  endtask

  initial begin
    test_reset();
    test_single();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_out_of_range();
    @(negedge clk);
    test_reset_abort(1);
    test_reset_abort(2);
    test_lat1();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
